// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the radix-2^2 SDF FFT control sequencer.
package fft_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } seq_state_t;

  // Enabled steps from an input sample to its appearance at the pipeline output.
  function automatic int unsigned pipe_lat_f(input int unsigned log2_n,
                                             input int unsigned stage_lat);
    return ((32'd1 << log2_n) - 32'd1) + log2_n * stage_lat;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v,
                                         input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) r[i] = v[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_cnt_delay.sv
// Step-enabled register chain delaying the sample counter by one butterfly stage.
module fft_cnt_delay #(
  parameter int unsigned W     = 6,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r [DEPTH];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r <= '{default: '0};
    end else if (en) begin
      r[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r[i] <= r[i-1];
      end
    end
  end

  assign q = r[DEPTH-1];

endmodule

// File: rtl/fft_sdf_sequencer.sv
// Control sequencer for a radix-2^2 SDF FFT: butterfly selects, fill/drain tracking, output framing.
// Build option: FFT_SEQ_BITREV_EN reports out_idx in bit-reversed order.
module fft_sdf_sequencer
  import fft_seq_pkg::*;
#(
  parameter int unsigned LOG2_N    = 6,
  parameter int unsigned STAGE_LAT = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic                  flush,
  output logic                  stage_en,
  output logic [LOG2_N-1:0]     s_vec,
  output logic [LOG2_N/2-1:0]   t_vec,
  output logic                  out_valid,
  output logic                  out_sof,
  output logic [LOG2_N-1:0]     out_idx,
  output logic                  flush_done,
  output logic                  sync_err
);

  localparam int unsigned PIPE_LAT = pipe_lat_f(LOG2_N, STAGE_LAT);
  localparam int unsigned FCW      = $clog2(PIPE_LAT + 1);
  localparam logic [FCW-1:0]    PIPE_LAT_C = FCW'(PIPE_LAT);
  localparam logic [FCW-1:0]    FC_ONE     = FCW'(1);
  localparam logic [LOG2_N-1:0] CNT_ONE    = LOG2_N'(1);

  seq_state_t        state, state_n;
  logic [LOG2_N-1:0] cnt, cnt_n;
  logic [LOG2_N-1:0] oc, oc_n;
  logic [FCW-1:0]    fc, fc_n;
  logic [FCW-1:0]    dc, dc_n;
  logic [LOG2_N-1:0] idx_map;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      oc    <= '0;
      fc    <= '0;
      dc    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      oc    <= oc_n;
      fc    <= fc_n;
      dc    <= dc_n;
    end
  end

  // fc parks at PIPE_LAT once the pipe is full, so FLUSH can tell whether
  // outputs have started or it must keep counting the fill on its own.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    oc_n       = oc;
    fc_n       = fc;
    dc_n       = dc;
    stage_en   = 1'b0;
    out_valid  = 1'b0;
    out_sof    = 1'b0;
    flush_done = 1'b0;
    sync_err   = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid && in_sof) begin
          stage_en = 1'b1;
          cnt_n    = CNT_ONE;
          fc_n     = FC_ONE;
          oc_n     = '0;
          state_n  = FILL;
        end
      end

      FILL, RUN: begin
        stage_en = in_valid;
        if (in_valid) begin
          if (in_sof && (cnt != '0)) begin
            sync_err = 1'b1;
            cnt_n    = CNT_ONE;
            fc_n     = FC_ONE;
            oc_n     = '0;
            state_n  = FILL;
          end else begin
            cnt_n = cnt + 1'b1;
            if (state == FILL) begin
              fc_n = fc + 1'b1;
              if (fc_n == PIPE_LAT_C) begin
                state_n = RUN;
                oc_n    = '0;
              end
            end else begin
              out_valid = 1'b1;
              out_sof   = (oc == '0);
              oc_n      = oc + 1'b1;
            end
          end
        end
        if (flush) begin
          state_n = FLUSH;
          dc_n    = PIPE_LAT_C;
        end
      end

      FLUSH: begin
        stage_en = 1'b1;
        cnt_n    = cnt + 1'b1;
        if (fc == PIPE_LAT_C) begin
          out_valid = 1'b1;
          out_sof   = (oc == '0);
          oc_n      = oc + 1'b1;
        end else begin
          fc_n = fc + 1'b1;
        end
        dc_n = dc - 1'b1;
        if (dc_n == '0) begin
          state_n    = IDLE;
          flush_done = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // Stage b sees the counter as it was b*STAGE_LAT steps ago.
  logic [LOG2_N-1:0] cnt_d [LOG2_N+1];
  logic              unused_cnt_tail;

  assign cnt_d[0] = cnt;

  for (genvar b = 0; b < LOG2_N; b++) begin : g_stage
    fft_cnt_delay #(
      .W     (LOG2_N),
      .DEPTH (STAGE_LAT)
    ) u_dly (
      .clock  (clock),
      .resetn (resetn),
      .en     (stage_en),
      .d      (cnt_d[b]),
      .q      (cnt_d[b+1])
    );
    assign s_vec[b] = cnt_d[b][LOG2_N-1-b];
  end

  for (genvar j = 0; j < LOG2_N/2; j++) begin : g_t
    assign t_vec[j] = cnt_d[2*j+1][LOG2_N-1-2*j];
  end

  assign unused_cnt_tail = ^cnt_d[LOG2_N];

`ifdef FFT_SEQ_BITREV_EN
  assign idx_map = LOG2_N'(bitrev(32'(oc), LOG2_N));
`else
  assign idx_map = oc;
`endif

  assign out_idx = out_valid ? idx_map : '0;

endmodule

// File: tb/tb_fft_sdf_sequencer.sv
// Directed bench for fft_sdf_sequencer (LOG2_N=4, STAGE_LAT=1) with an output scoreboard.
module tb_fft_sdf_sequencer;

  localparam int LN = 4;
  localparam int PL = 19;

  logic          clock;
  logic          resetn;
  logic          in_valid;
  logic          in_sof;
  logic          flush;
  logic          stage_en;
  logic [LN-1:0] s_vec;
  logic [LN/2-1:0] t_vec;
  logic          out_valid;
  logic          out_sof;
  logic [LN-1:0] out_idx;
  logic          flush_done;
  logic          sync_err;

  fft_sdf_sequencer #(
    .LOG2_N    (LN),
    .STAGE_LAT (1)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .flush      (flush),
    .stage_en   (stage_en),
    .s_vec      (s_vec),
    .t_vec      (t_vec),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_idx    (out_idx),
    .flush_done (flush_done),
    .sync_err   (sync_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum {M_IDLE, M_ACTIVE, M_FLUSH} m_state_t;
  typedef struct {
    int         due;
    logic [3:0] idx;
  } sb_t;

  sb_t        sb[$];
  m_state_t   m_st;
  int         step_count;
  int         m_dc;
  logic [3:0] my_cnt;
  logic [3:0] frame_i;
  logic [3:0] hist [0:1023];
  int         n_tests;
  int         n_fail;
  int         obs_valid_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (step %0d)", tag, obs, exp, step_count);
    end
  endtask

  function automatic logic [3:0] map_idx(input logic [3:0] i);
`ifdef FFT_SEQ_BITREV_EN
    return {i[0], i[1], i[2], i[3]};
`else
    return i;
`endif
  endfunction

  function automatic logic hist_bit(input int k, input int b, input int bi);
    if (k - b < 0) return 1'b0;
    return hist[(k-b) % 1024][bi];
  endfunction

  task automatic model_reset();
    sb.delete();
    m_st       = M_IDLE;
    step_count = 0;
    m_dc       = 0;
    my_cnt     = '0;
    frame_i    = '0;
  endtask

  task automatic tick(input logic v, input logic sof, input logic fl);
    logic       exp_step, exp_valid, exp_sof, exp_done, resync, acc;
    logic [3:0] exp_idx, exp_s;
    logic [1:0] exp_t;
    sb_t        e;
    @(negedge clock);
    in_valid = v;
    in_sof   = sof;
    flush    = fl;
    #1;
    hist[step_count % 1024] = my_cnt;
    exp_step = (m_st == M_FLUSH) ? 1'b1 : (m_st == M_IDLE) ? (v & sof) : v;
    acc      = (m_st == M_IDLE) ? (v & sof) : (m_st == M_ACTIVE) ? v : 1'b0;
    resync   = (m_st == M_ACTIVE) && v && sof && (my_cnt != 4'd0);
    exp_done = (m_st == M_FLUSH) && (m_dc == 1);
    if (resync) sb.delete();
    exp_valid = 1'b0;
    exp_sof   = 1'b0;
    exp_idx   = '0;
    if (exp_step && sb.size() > 0 && sb[0].due == step_count) begin
      e         = sb.pop_front();
      exp_valid = 1'b1;
      exp_idx   = map_idx(e.idx);
      exp_sof   = (e.idx == 4'd0);
    end
    for (int b = 0; b < LN; b++) exp_s[b] = hist_bit(step_count, b, LN-1-b);
    for (int j = 0; j < LN/2; j++) exp_t[j] = hist_bit(step_count, 2*j+1, LN-1-2*j);

    check("stage_en", stage_en, exp_step);
    check("sync_err", sync_err, resync);
    check("out_valid", out_valid, exp_valid);
    check("out_sof", out_sof, exp_sof);
    if (exp_valid) check("out_idx", out_idx, exp_idx);
    check("s_vec", s_vec, exp_s);
    check("t_vec", t_vec, exp_t);
    check("flush_done", flush_done, exp_done);
    if (out_valid === 1'b1) obs_valid_cnt++;

    if (exp_step) begin
      if (acc) begin
        if (sof) frame_i = '0;
        e.due = step_count + PL;
        e.idx = frame_i;
        sb.push_back(e);
        frame_i = frame_i + 4'd1;
      end
      my_cnt = (acc && sof) ? 4'd1 : my_cnt + 4'd1;
      step_count++;
    end
    case (m_st)
      M_IDLE:   if (acc) m_st = M_ACTIVE;
      M_ACTIVE: if (fl) begin m_st = M_FLUSH; m_dc = PL; end
      M_FLUSH: begin
        m_dc--;
        if (m_dc == 0) m_st = M_IDLE;
      end
      default: m_st = M_IDLE;
    endcase
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_stage_en"}, stage_en, 0);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_out_sof"}, out_sof, 0);
    check({pfx, "_out_idx"}, out_idx, 0);
    check({pfx, "_s_vec"}, s_vec, 0);
    check({pfx, "_t_vec"}, t_vec, 0);
    check({pfx, "_flush_done"}, flush_done, 0);
    check({pfx, "_sync_err"}, sync_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, v0, acc3, guard;
    n_tests = 0;
    n_fail = 0;
    obs_valid_cnt = 0;
    resetn = 1'b0;
    in_valid = 1'b1;
    in_sof = 1'b0;
    flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    resetn = 1'b1;

    // Continuous frames, then flush on an idle-input cycle
    tick(1'b1, 1'b1, 1'b0);
    repeat (47) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    repeat (PL) tick(1'b0, 1'b0, 1'b0);
    check("drain_queue_empty", sb.size(), 0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);

    // Random stalls
    s0 = step_count;
    v0 = obs_valid_cnt;
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 80; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    acc3 = step_count - s0;
    check("stall_out_count", obs_valid_cnt - v0, (acc3 > PL) ? acc3 - PL : 0);

    // Mid-frame resync at cnt=5, then 32-sample frame ending with flush+valid
    guard = 0;
    while (my_cnt != 4'd5 && guard < 32) begin
      tick(1'b1, 1'b0, 1'b0);
      guard++;
    end
    check("reach_cnt5", my_cnt, 5);
    tick(1'b1, 1'b1, 1'b0);
    repeat (30) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < PL; i++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    check("flush2_queue_empty", sb.size(), 0);
    tick(1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RUN
    tick(1'b1, 1'b1, 1'b0);
    repeat (24) tick(1'b1, 1'b0, 1'b0);
    @(negedge clock);
    in_valid = 1'b1;
    in_sof = 1'b0;
    flush = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    repeat (22) tick(1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_sdf_sequencer.md
Name: fft_sdf_sequencer

Overview:
- Control sequencer for a radix-2² single-path delay-feedback FFT pipeline made of alternating BF2I/BF2II stages; the last BF2II stage has no multiplier.
- Counts input samples and generates per-stage s/t butterfly selects and a shared shift-register enable.
- Aligns each stage's selects with that stage's pipeline delay.
- Tracks pipeline fill and drain, and emits output valid, start-of-frame and output sample index.

Parameters:
- LOG2_N, 6, log2 of FFT size N; must be even and ≥ 2.
- STAGE_LAT, 1, registered cycles each butterfly stage adds on the forward path (the stage output register).
- localparam PIPE_LAT = (N-1) + LOG2_N*STAGE_LAT: enabled steps from an input sample to the first output.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  input sample present this cycle
- in_sof  in  1  qualifies in_valid; marks sample index 0
- flush  in  1  pulse; drain the pipeline with no further input
- stage_en  out  1  enable to all stage shift registers
- s_vec  out  LOG2_N  s select, bit b for butterfly b (b=0 first, even b = BF2I, odd b = BF2II)
- t_vec  out  LOG2_N/2  t select for each BF2II
- out_valid  out  1  pipeline output valid
- out_sof  out  1  first output of a frame
- out_idx  out  LOG2_N  frequency index of the current output
- flush_done  out  1  one-cycle pulse when drain completes
- sync_err  out  1  one-cycle pulse on in_sof mid-frame

Behaviour:
- Reset (async, resetn=0):
  - State IDLE; all counters 0.
  - All outputs 0.
- Step definition: step = stage_en. stage_en = in_valid in FILL or RUN; 1 in FLUSH; 0 in IDLE except the accepting in_sof sample.
- cnt (LOG2_N bits):
  - Increments on every step and wraps N-1 → 0.
  - in_sof with in_valid loads 1, because the sof sample itself is index 0.
- Select alignment:
  - Butterfly b uses cnt_b, which is cnt delayed by b*STAGE_LAT steps.
  - s_vec[b] = cnt_b[LOG2_N-1-b].
  - t_vec[j] = cnt_{2j+1}[LOG2_N-1-2j].
  - Selects are combinational from registered cnt_b and hold while stage_en=0.
- State machine:
  - IDLE → FILL on in_valid & in_sof; fill counter fc = 1.
  - FILL: fc increments per step. When fc reaches PIPE_LAT → RUN; that step asserts out_valid=1 and out_sof=1 with out_idx=0.
  - RUN: out_valid = stage_en. Output counter oc increments per step and wraps at N. out_sof=1 when oc==0 and stage_en=1.
  - FILL or RUN with flush=1 → FLUSH; drain counter dc = PIPE_LAT.
  - FLUSH:
    - stage_en=1 every cycle, so zeros must be fed by the datapath owner. in_valid is ignored.
    - Outputs remain valid until the last real sample exits, i.e. PIPE_LAT steps after the final accepted input.
    - dc decrements to 0 → IDLE; flush_done pulses that cycle.
  - flush in IDLE: ignored, no flush_done.
  - flush in FLUSH: ignored.
- Simultaneous events and errors:
  - in_sof with in_valid in FILL/RUN where cnt≠0 (mid-frame): sync_err pulses, cnt reloads 1, fc restarts at 1, state → FILL, out_valid drops.
  - in_sof at cnt==0 is a normal frame boundary; no error.
  - flush and in_valid in the same cycle: the sample is accepted, then FLUSH is entered.
- Latency:
  - The first out_valid follows the sof sample by exactly PIPE_LAT steps.
  - Stalls (in_valid=0) freeze all counters; latency is in steps, not cycles.
- Width and arithmetic:
  - All counters wrap modulo 2^width.
  - fc and dc are clog2(PIPE_LAT+1) bits.
  - No saturation anywhere.

Optional Feature:
- Macro: FFT_SEQ_BITREV_EN.
- Defined: out_idx = bit-reverse(oc), matching the pipeline's bit-reversed output order.
- Undefined: out_idx = oc in natural order; the consumer reorders.

Decomposition:
- Package fft_seq_pkg holds:
  - state enum IDLE/FILL/RUN/FLUSH;
  - a function computing PIPE_LAT from LOG2_N and STAGE_LAT;
  - a bitrev function.
- Sub-module fft_cnt_delay: a STAGE_LAT-deep, step-enabled register chain. It is instantiated LOG2_N times in a cascade to produce cnt_b.

Test Plan:
All scenarios use LOG2_N=4, STAGE_LAT=1, PIPE_LAT=19.
1. Reset: resetn low mid-RUN → all outputs 0 immediately; state IDLE after release.
2. Continuous frames: sof then 48 valid samples →
   - first out_valid/out_sof on step 19;
   - out_sof every 16 steps thereafter;
   - s_vec[0] toggles every 8 steps, s_vec[3] every step (delayed 3).
3. Stalls: same as scenario 2 with in_valid 50% random → out_valid count equals accepted steps minus 19; selects are frozen during gaps.
4. Resync: sof at cnt=5 → sync_err pulse, cnt=1 next, out_valid low for 19 steps.
5. Flush: after 32 samples, flush → stage_en=1 for 19 cycles, outputs valid throughout, flush_done on cycle 19, then IDLE. A second flush while in IDLE produces nothing.
6. With FFT_SEQ_BITREV_EN: out_idx sequence 0,8,4,12,2,…; without the macro: 0,1,2,….
